mfp_uart_transmitter: RTL and testbench
=======================================

# mfp_uart_transmitter

Byte-stream-to-serial UART transmitter (8N1) with a small input FIFO. It drives the line that the system's `UART_RX` input samples, so it serves as the host-side stimulus source in simulation and as a loopback or second-port transmitter on the board. Bytes enter through a valid/ready handshake, are buffered, and are shifted out LSB-first at a fixed bit period set in clock cycles.

## Interface
Parameters:
- `CLKS_PER_BIT`, 434: clock cycles per UART bit (50 MHz / 115200); legal range ≥ 2.
- `FIFO_DEPTH_LOG2`, 2: FIFO holds 2^`FIFO_DEPTH_LOG2` bytes (default 4).

Ports:
- `HCLK`  in  1  system clock; all state changes on its rising edge.
- `HRESETn`  in  1  asynchronous, active-low reset.
- `tx_data`  in  8  byte to send; sampled when `tx_valid && tx_ready`.
- `tx_valid`  in  1  producer offers `tx_data`.
- `tx_ready`  out  1  FIFO not full; combinational from FIFO count.
- `UART_TX`  out  1  serial line, registered, idles high.
- `busy`  out  1  high while a frame is on the line or the FIFO is non-empty.
- `fifo_count`  out  `FIFO_DEPTH_LOG2`+1  bytes currently buffered, excluding the byte being shifted.

## Operation
- FIFO: circular buffer with read/write pointers of width `FIFO_DEPTH_LOG2` that wrap naturally, plus a count register.
  - Push on `tx_valid && tx_ready`.
  - Pop when the FSM loads a byte.
  - `tx_ready = (fifo_count != 2^FIFO_DEPTH_LOG2)`.
  - Push and pop in the same cycle leave the count unchanged. When the FIFO is full, `tx_ready` is 0 even if a pop occurs that cycle; no push happens.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: `UART_TX`=1. If the FIFO is non-empty, pop into the 8-bit shift register, clear the baud counter and go to START.
  - START: `UART_TX`=0 for `CLKS_PER_BIT` cycles, then go to DATA with the bit index at 0.
  - DATA: `UART_TX` = shift[0] for `CLKS_PER_BIT` cycles, then shift right and increment the index. After index 7 completes, go to STOP.
  - STOP: `UART_TX`=1 for `CLKS_PER_BIT` cycles. On the last STOP cycle:
    - if the FIFO is non-empty, pop and go directly to START, with no idle cycle between frames;
    - otherwise go to IDLE.
- Baud counter: counts 0..`CLKS_PER_BIT`-1. Its width is `$clog2(CLKS_PER_BIT)`. The bit ends when the counter reaches `CLKS_PER_BIT`-1, and the counter then returns to 0.
- `busy` = (state != IDLE) || (`fifo_count` != 0).
- Reset (any time, including mid-frame):
  - `UART_TX`=1, state IDLE, FIFO emptied, counters cleared, `fifo_count`=0, `busy`=0.
  - `tx_ready`=1 while `HRESETn` is high.
  - A partially sent frame is abandoned. The line returns high immediately, which the receiver sees as a framing error; this is accepted behaviour.

## Timing
- Reset values: `UART_TX`=1, `busy`=0, `fifo_count`=0, `tx_ready`=1.
- Push at edge N into an empty FIFO with the FSM in IDLE:
  - `fifo_count`=1 after edge N.
  - The FSM pops at edge N+1, so `UART_TX` falls after edge N+1 and `fifo_count` returns to 0.
  - Push-to-start-bit latency is 2 cycles.
- Frame length is exactly 10×`CLKS_PER_BIT` cycles: the start bit, data bits 0..7 (LSB first) and the stop bit each last exactly `CLKS_PER_BIT` cycles.
- Back-to-back frames: the next start bit begins the cycle after the last stop cycle. The line period for N queued bytes is N×10×`CLKS_PER_BIT` cycles.
- Throughput: the FIFO plus the shift register holds up to 2^`FIFO_DEPTH_LOG2`+1 bytes in flight.
- `tx_valid` held high while `tx_ready`=0 must not cause a push. Each accepted handshake sends exactly one byte.

## Test plan
- Reset: hold `HRESETn`=0 for 5 cycles, then release. Required: `UART_TX`=1, `busy`=0, `fifo_count`=0 and `tx_ready`=1 throughout and after release.
- Single byte, `CLKS_PER_BIT`=4: push 0x55 at cycle 10. Required:
  - `UART_TX` low during cycles 12–15;
  - then bit pattern 1,0,1,0,1,0,1,0, four cycles each, over cycles 16–47;
  - high for the stop bit in cycles 48–51;
  - `busy` falls after cycle 51.
- Back-to-back: push 0xA5 then 0x3C on consecutive cycles. Required:
  - decoded bytes are 0xA5 then 0x3C;
  - the second start bit begins immediately after the first stop bit, with no extra high cycle;
  - total low-to-idle span is 80 cycles at `CLKS_PER_BIT`=4.
- Full FIFO: hold `tx_valid`=1 with bytes 0x01..0x08. Required:
  - 5 bytes accepted (1 in the shift register, 4 in the FIFO);
  - `tx_ready`=0 with `fifo_count`=4;
  - `tx_ready` reasserts one cycle after the next pop;
  - all 8 bytes appear on the line in order with no duplicates.
- Reset mid-frame: assert `HRESETn`=0 during data bit 3 of 0xF0 with 2 bytes queued. Required:
  - `UART_TX`=1 asynchronously;
  - `fifo_count`=0;
  - after release, the line stays high and no further frame is sent without a new push.
- Wrap-around: stream 20 bytes (0x00..0x13) with `tx_valid` toggling pseudo-randomly. Required: a reference receiver decodes exactly 0x00..0x13 in order, and `fifo_count` never exceeds 4.

Source files
------------

// File: rtl/mfp_uart_transmitter.sv
// rtl/mfp_uart_transmitter.sv - 8N1 UART transmitter fed by a small byte FIFO
module mfp_uart_transmitter #(
  parameter int CLKS_PER_BIT    = 434,
  parameter int FIFO_DEPTH_LOG2 = 2
) (
  input  logic                     HCLK,
  input  logic                     HRESETn,
  input  logic [7:0]               tx_data,
  input  logic                     tx_valid,
  output logic                     tx_ready,
  output logic                     UART_TX,
  output logic                     busy,
  output logic [FIFO_DEPTH_LOG2:0] fifo_count
);
  localparam int BW    = $clog2(CLKS_PER_BIT);
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam logic [BW-1:0]              BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_DEPTH_LOG2:0]   COUNT_FULL = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t                     r_state, w_state_next;
  logic [7:0]                 r_mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] r_wptr, r_rptr;
  logic [FIFO_DEPTH_LOG2:0]   r_count;
  logic [7:0]                 r_shift, w_shift_next;
  logic [BW-1:0]              r_baud, w_baud_next;
  logic [2:0]                 r_idx, w_idx_next;
  logic                       r_tx, w_tx_next;
  logic                       w_push, w_pop, w_bit_end, w_fifo_empty;

  assign w_fifo_empty = (r_count == '0);
  assign w_bit_end    = (r_baud == BAUD_LAST);
  assign tx_ready     = (r_count != COUNT_FULL);
  assign w_push       = tx_valid && tx_ready;
  assign fifo_count   = r_count;
  assign UART_TX      = r_tx;
  assign busy         = (r_state != S_IDLE) || !w_fifo_empty;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge HCLK) begin
    if (w_push) r_mem[r_wptr] <= tx_data;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_baud  <= '0;
      r_idx   <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_shift <= w_shift_next;
      r_baud  <= w_baud_next;
      r_idx   <= w_idx_next;
      r_tx    <= w_tx_next;
    end
  end

  // The line is registered from the next state so the start bit appears on the popping edge.
  always_comb begin
    w_state_next = r_state;
    w_shift_next = r_shift;
    w_baud_next  = r_baud;
    w_idx_next   = r_idx;
    w_pop        = 1'b0;
    w_tx_next    = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (!w_fifo_empty) begin
          w_pop        = 1'b1;
          w_shift_next = r_mem[r_rptr];
          w_baud_next  = '0;
          w_state_next = S_START;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_baud_next  = '0;
          w_idx_next   = '0;
          w_state_next = S_DATA;
        end else begin
          w_baud_next = r_baud + 1'b1;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_baud_next  = '0;
          w_shift_next = {1'b0, r_shift[7:1]};
          w_idx_next   = r_idx + 3'd1;
          if (r_idx == 3'd7) w_state_next = S_STOP;
        end else begin
          w_baud_next = r_baud + 1'b1;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          w_baud_next = '0;
          if (!w_fifo_empty) begin
            w_pop        = 1'b1;
            w_shift_next = r_mem[r_rptr];
            w_state_next = S_START;
          end else begin
            w_state_next = S_IDLE;
          end
        end else begin
          w_baud_next = r_baud + 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
    case (w_state_next)
      S_START: w_tx_next = 1'b0;
      S_DATA:  w_tx_next = w_shift_next[0];
      default: w_tx_next = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_mfp_uart_transmitter.sv
// tb/tb_mfp_uart_transmitter.sv - directed bench for mfp_uart_transmitter at 4 clocks per bit
module tb_mfp_uart_transmitter;
  localparam int CPB = 4;
  localparam int L2  = 2;

  logic         clk = 1'b0;
  logic         HRESETn;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         tx_ready;
  logic         UART_TX;
  logic         busy;
  logic [L2:0]  fifo_count;

  int total = 0;
  int bad   = 0;

  mfp_uart_transmitter #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH_LOG2(L2)) dut (
    .HCLK(clk), .HRESETn(HRESETn), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .UART_TX(UART_TX), .busy(busy), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference receiver: first low sample is cnt 0, data bit i sampled at 5+4i, stop at 37.
  logic [7:0] rx_q[$];
  logic [7:0] rx_sh;
  bit         rx_busy = 0;
  int         rx_cnt  = 0;
  int         rx_ferr = 0;
  int         max_fc  = 0;

  always @(negedge clk) begin
    if (int'(fifo_count) > max_fc) max_fc = int'(fifo_count);
    if (!HRESETn) begin
      rx_busy = 0;
    end else if (!rx_busy) begin
      if (UART_TX == 1'b0) begin
        rx_busy = 1;
        rx_cnt  = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt >= 5 && rx_cnt <= 33 && ((rx_cnt - 5) % 4) == 0)
        rx_sh[(rx_cnt - 5) / 4] = UART_TX;
      if (rx_cnt == 37 && UART_TX !== 1'b1) rx_ferr++;
      if (rx_cnt == 39) begin
        rx_q.push_back(rx_sh);
        rx_busy = 0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  logic [44:0] line_s, line_e;
  logic [44:0] busy_s;
  logic [7:0]  b55;
  logic [7:0]  exp8;
  int k, acc, cyc, stall_len, lows, highs, fc_at1;
  bit stall_seen, stall_done, will, l39, l40;

  initial begin
    HRESETn  = 1'b0;
    tx_data  = 8'h00;
    tx_valid = 1'b0;

    // Reset
    repeat (2) @(negedge clk);
    chk("rst_tx", UART_TX, 1);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", fifo_count, 0);
    chk("rst_ready", tx_ready, 1);
    repeat (3) @(negedge clk);
    HRESETn = 1'b1;
    repeat (2) @(negedge clk);
    chk("rel_tx", UART_TX, 1);
    chk("rel_busy", busy, 0);
    chk("rel_cnt", fifo_count, 0);
    chk("rel_ready", tx_ready, 1);

    // Single byte 0x55
    rx_q.delete();
    b55 = 8'h55;
    tx_data = b55; tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    chk("push_cnt", fifo_count, 1);
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      line_s[i] = UART_TX;
      busy_s[i] = busy;
      if (i == 1) fc_at1 = int'(fifo_count);
    end
    for (int i = 0; i < 45; i++) begin
      if (i >= 1 && i <= 4)       line_e[i] = 1'b0;
      else if (i >= 5 && i <= 36) line_e[i] = b55[(i - 5) / 4];
      else                        line_e[i] = 1'b1;
    end
    chk("single_line", line_s, line_e);
    chk("single_pop_cnt", fc_at1, 0);
    chk("single_busy_last_stop", busy_s[40], 1);
    chk("single_busy_fall", busy_s[41], 0);
    chk("single_rx_n", rx_q.size(), 1);
    if (rx_q.size() >= 1) chk("single_rx_byte", rx_q[0], 8'h55);

    // Back-to-back 0xA5, 0x3C
    rx_q.delete();
    @(negedge clk);
    tx_data = 8'hA5; tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_data = 8'h3C;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    k = 0;
    @(negedge clk);
    while (UART_TX !== 1'b0 && k < 20) begin @(negedge clk); k++; end
    chk("b2b_start_seen", k < 20, 1);
    k = 0; l39 = 0; l40 = 1;
    while (busy && k < 200) begin
      if (k == 39) l39 = UART_TX;
      if (k == 40) l40 = UART_TX;
      @(negedge clk);
      k++;
    end
    chk("b2b_span", k, 80);
    chk("b2b_stop1", l39, 1);
    chk("b2b_start2", l40, 0);
    chk("b2b_rx_n", rx_q.size(), 2);
    if (rx_q.size() >= 2) begin
      chk("b2b_rx0", rx_q[0], 8'hA5);
      chk("b2b_rx1", rx_q[1], 8'h3C);
    end

    // Full FIFO with bytes 0x01..0x08 and tx_valid held high
    rx_q.delete();
    acc = 0; cyc = 0; stall_len = 0; stall_seen = 0; stall_done = 0;
    while (acc < 8 && cyc < 2000) begin
      @(negedge clk);
      tx_data  = 8'(acc + 1);
      tx_valid = 1'b1;
      if (!tx_ready) begin
        if (!stall_seen) begin
          stall_seen = 1;
          chk("full_accepted", acc, 5);
          chk("full_cnt", fifo_count, 4);
        end
        if (!stall_done) stall_len++;
      end else if (stall_seen) begin
        stall_done = 1;
      end
      will = tx_ready;
      @(posedge clk);
      if (will) acc++;
      cyc++;
    end
    #1 tx_valid = 1'b0;
    chk("full_all_accepted", acc, 8);
    chk("full_stall_len", stall_len, 37);
    k = 0;
    while (busy && k < 1000) begin @(negedge clk); k++; end
    chk("full_drain", busy, 0);
    chk("full_rx_n", rx_q.size(), 8);
    for (int i = 0; i < rx_q.size() && i < 8; i++) begin
      exp8 = 8'(i + 1);
      chk($sformatf("full_rx%0d", i), rx_q[i], exp8);
    end

    // Reset during data bit 3 of 0xF0 with two bytes queued
    rx_q.delete();
    @(negedge clk);
    tx_data = 8'hF0; tx_valid = 1'b1;
    @(posedge clk); #1 tx_data = 8'h11;
    @(posedge clk); #1 tx_data = 8'h22;
    @(posedge clk); #1 tx_valid = 1'b0;
    k = 0;
    @(negedge clk);
    while (UART_TX !== 1'b0 && k < 20) begin @(negedge clk); k++; end
    chk("mid_start_seen", k < 20, 1);
    repeat (18) @(negedge clk);
    chk("mid_bit3_low", UART_TX, 0);
    chk("mid_cnt_before", fifo_count, 2);
    #2 HRESETn = 1'b0;
    #1;
    chk("mid_tx_async", UART_TX, 1);
    chk("mid_cnt", fifo_count, 0);
    chk("mid_busy", busy, 0);
    repeat (3) @(negedge clk);
    HRESETn = 1'b1;
    lows = 0; highs = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (UART_TX !== 1'b1) lows++;
      if (busy !== 1'b0) highs++;
    end
    chk("mid_line_quiet", lows, 0);
    chk("mid_busy_quiet", highs, 0);
    chk("mid_rx_n", rx_q.size(), 0);

    // Wrap-around stream 0x00..0x13 with pseudo-random tx_valid
    rx_q.delete();
    max_fc = 0;
    acc = 0; cyc = 0;
    while (acc < 20 && cyc < 20000) begin
      @(negedge clk);
      tx_data  = 8'(acc);
      tx_valid = 1'($urandom_range(0, 1));
      will = tx_valid && tx_ready;
      @(posedge clk);
      if (will) acc++;
      cyc++;
    end
    #1 tx_valid = 1'b0;
    chk("wrap_accepted", acc, 20);
    k = 0;
    while (busy && k < 2000) begin @(negedge clk); k++; end
    chk("wrap_drain", busy, 0);
    chk("wrap_rx_n", rx_q.size(), 20);
    for (int i = 0; i < rx_q.size() && i < 20; i++) begin
      exp8 = 8'(i);
      chk($sformatf("wrap_rx%0d", i), rx_q[i], exp8);
    end
    chk("wrap_max_cnt_le4", max_fc <= 4, 1);
    chk("framing_errors", rx_ferr, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
